// File: rtl/shift_seq.sv
// Multi-step rotate sequencer: latches a command, drives the shifter select
// lines one rotate per clock and returns the final result with a done pulse.
module shift_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       din,
  output logic             busy,
  output logic             done,
  output logic [7:0]       dout,
  output logic             cf_out,
  output logic             fbus,
  output logic             flbus,
  output logic             frbus,
  output logic [7:0]       a,
  input  logic [7:0]       w,
  input  logic             cf
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      carry_q <= 1'b0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  // w is only captured in RUN/PASS; in IDLE/DONE the shifter floats it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    fbus    = 1'b0;
    flbus   = 1'b0;
    frbus   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = din;
          dir_d   = dir;
          rem_d   = cnt;
          carry_d = 1'b0;
          state_d = (cnt == '0) ? PASS : RUN;
        end
      end
      RUN: begin
        flbus   = ~dir_q;
        frbus   = dir_q;
        data_d  = w;
        carry_d = cf;
        rem_d   = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) state_d = DONE;
      end
      PASS: begin
        fbus    = 1'b1;
        data_d  = w;
        carry_d = cf;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign a      = data_q;
  assign dout   = data_q;
  assign cf_out = carry_q;

endmodule
